// File: rtl/clkmux_pkg.sv
// Shared definitions for the clock-mux switch sequencer: state encoding,
// mux selector constants and the saturating counter helper.
package clkmux_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_QUIESCE,
    ST_SWITCH,
    ST_SETTLE,
    ST_RELEASE,
    ST_FINISH
  } state_t;

  localparam logic CLKSEL_A = 1'b1;
  localparam logic CLKSEL_B = 1'b0;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == '1) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/clock_mux_sequencer.sv
// Sequences a glitch-safe clock mux switch: quiesce downstream, pulse the mux
// select enable, settle, release the quiesce, then report DONE or ERR.
module clock_mux_sequencer
  import clkmux_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned QUIESCE_TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_VALID,
  input  logic REQ_SEL,
  output logic REQ_READY,
  output logic QUIESCE_REQ,
  input  logic QUIESCE_ACK,
  output logic SELECT,
  output logic SELECT_ENABLE,
  output logic CUR_SEL,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(QUIESCE_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       cur_sel, target;
  logic       rst_hold;
  logic       timeout_hit;

  // rst_hold keeps the INIT select-enable pulse off while RST is held and
  // delays the INIT->IDLE step so INIT lasts one full cycle after release.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_INIT;
      rst_hold <= 1'b1;
      cnt      <= '0;
      cur_sel  <= CLKSEL_B;
      target   <= CLKSEL_B;
    end else begin
      state    <= state_nxt;
      rst_hold <= 1'b0;
      cnt      <= cnt_nxt;
      if (state == ST_SWITCH)
        cur_sel <= target;
      if (state == ST_IDLE && REQ_VALID && REQ_SEL != cur_sel)
        target <= REQ_SEL;
    end
  end

  assign timeout_hit = (state == ST_QUIESCE) && (cnt == TIMEOUT_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT:
        if (!rst_hold) state_nxt = ST_IDLE;
      ST_IDLE:
        if (REQ_VALID) begin
          if (REQ_SEL == cur_sel) begin
            state_nxt = ST_FINISH;
          end else begin
            state_nxt = ST_QUIESCE;
            cnt_nxt   = '0;
          end
        end
      ST_QUIESCE:
        // Timeout wins over a late ACK because ERR is already asserted this cycle.
        if (timeout_hit)      state_nxt = ST_IDLE;
        else if (QUIESCE_ACK) state_nxt = ST_SWITCH;
        else                  cnt_nxt   = sat_inc(cnt);
      ST_SWITCH: begin
        state_nxt = ST_SETTLE;
        cnt_nxt   = '0;
      end
      ST_SETTLE:
        if (cnt == SETTLE_LAST) state_nxt = ST_RELEASE;
        else                    cnt_nxt   = sat_inc(cnt);
      ST_RELEASE:
        if (!QUIESCE_ACK) state_nxt = ST_FINISH;
      ST_FINISH:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_INIT;
    endcase
  end

  assign REQ_READY     = (state == ST_IDLE);
  assign BUSY          = (state != ST_IDLE);
  assign QUIESCE_REQ   = (state == ST_QUIESCE) || (state == ST_SWITCH) || (state == ST_SETTLE);
  assign SELECT_ENABLE = (state == ST_SWITCH) || ((state == ST_INIT) && !rst_hold);
  assign SELECT        = (state == ST_SWITCH) ? target : cur_sel;
  assign CUR_SEL       = cur_sel;
  assign DONE          = (state == ST_FINISH);
  assign ERR           = timeout_hit;

endmodule

// File: tb/tb_clock_mux_sequencer.sv
// Directed bench for clock_mux_sequencer; DONE/ERR pulses are checked against
// a scoreboard of expected events and cycle numbers.
module tb_clock_mux_sequencer;
  import clkmux_pkg::*;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic REQ_VALID = 1'b0;
  logic REQ_SEL = 1'b0;
  logic QUIESCE_ACK = 1'b0;
  logic REQ_READY, QUIESCE_REQ, SELECT, SELECT_ENABLE, CUR_SEL, BUSY, DONE, ERR;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int se_count = 0;
  int qr_count = 0;

  typedef struct {
    bit err;
    int cyc;
  } ev_t;
  ev_t sb[$];

  clock_mux_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .QUIESCE_TIMEOUT(TIMEOUT)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_VALID    (REQ_VALID),
    .REQ_SEL      (REQ_SEL),
    .REQ_READY    (REQ_READY),
    .QUIESCE_REQ  (QUIESCE_REQ),
    .QUIESCE_ACK  (QUIESCE_ACK),
    .SELECT       (SELECT),
    .SELECT_ENABLE(SELECT_ENABLE),
    .CUR_SEL      (CUR_SEL),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERR          (ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_ev(input bit err, input int at);
    ev_t e;
    e.err = err;
    e.cyc = at;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    ev_t e;
    if (SELECT_ENABLE) se_count++;
    if (QUIESCE_REQ) qr_count++;
    if (DONE || ERR) begin
      chk("sb_event_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_kind_done_err", {30'd0, DONE, ERR}, e.err ? 32'd1 : 32'd2);
        chk("sb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int c, se0, qr0;

    // Reset held for 3 cycles
    step(); step(); step();
    chk("rst_se", SELECT_ENABLE, 0);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_qreq", QUIESCE_REQ, 0);
    chk("rst_sel", SELECT, 0);
    chk("rst_cur", CUR_SEL, 0);
    chk("rst_done_err", {DONE, ERR}, 0);
    RST = 1'b0;
    step();
    chk("init_se", SELECT_ENABLE, 1);
    chk("init_sel", SELECT, 0);
    chk("init_ready", REQ_READY, 0);
    step();
    chk("idle_ready", REQ_READY, 1);
    chk("idle_busy", BUSY, 0);
    chk("idle_cur", CUR_SEL, 0);
    chk("init_se_pulses", se_count, 1);

    // Switch to A, ACK on 2nd quiesce cycle, held into RELEASE; busy-time requests toggled
    c = cyc; se0 = se_count; qr0 = qr_count;
    REQ_VALID = 1'b1; REQ_SEL = 1'b1;
    expect_ev(1'b0, c + 10);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) chk("sw_q_ready", REQ_READY, 0);
      if (k == 3) begin
        chk("sw_se", SELECT_ENABLE, 1);
        chk("sw_sel", SELECT, 1);
        chk("sw_cur_before", CUR_SEL, 0);
      end
      if (k == 8) chk("sw_release_qreq", QUIESCE_REQ, 0);
      if (k <= 8) begin
        REQ_VALID = k[0];
        REQ_SEL = ~k[0];
      end else begin
        REQ_VALID = 1'b0;
      end
      if (k == 2) QUIESCE_ACK = 1'b1;
      if (k == 9) QUIESCE_ACK = 1'b0;
    end
    step();
    chk("sw_cur_after", CUR_SEL, 1);
    chk("sw_sel_after", SELECT, 1);
    chk("sw_se_pulses", se_count - se0, 1);
    chk("sw_qreq_cycles", qr_count - qr0, 7);
    chk("sw_ready_after", REQ_READY, 1);

    // Same-source request
    c = cyc; se0 = se_count; qr0 = qr_count;
    REQ_VALID = 1'b1; REQ_SEL = 1'b1;
    expect_ev(1'b0, c + 1);
    step();
    REQ_VALID = 1'b0;
    chk("same_done", DONE, 1);
    chk("same_qreq", QUIESCE_REQ, 0);
    chk("same_se", SELECT_ENABLE, 0);
    step();
    chk("same_ready", REQ_READY, 1);
    chk("same_se_none", se_count - se0, 0);
    chk("same_qreq_none", qr_count - qr0, 0);

    // Quiesce timeout with ACK held low
    c = cyc; se0 = se_count;
    REQ_VALID = 1'b1; REQ_SEL = 1'b0; QUIESCE_ACK = 1'b0;
    expect_ev(1'b1, c + 8);
    step();
    REQ_VALID = 1'b0;
    repeat (7) step();
    chk("to_err", ERR, 1);
    chk("to_done", DONE, 0);
    step();
    chk("to_ready", REQ_READY, 1);
    chk("to_err_cleared", ERR, 0);
    chk("to_cur", CUR_SEL, 1);
    chk("to_sel", SELECT, 1);
    chk("to_se_none", se_count - se0, 0);

    // Minimum latency back to B with immediate ACK
    c = cyc;
    REQ_VALID = 1'b1; REQ_SEL = 1'b0; QUIESCE_ACK = 1'b1;
    expect_ev(1'b0, c + int'(SETTLE) + 4);
    step();
    REQ_VALID = 1'b0;
    step();
    QUIESCE_ACK = 1'b0;
    chk("ml_se", SELECT_ENABLE, 1);
    chk("ml_sel", SELECT, 0);
    repeat (SETTLE + 2) step();
    chk("ml_done", DONE, 1);
    step();
    chk("ml_cur", CUR_SEL, 0);

    // Reset during SETTLE abandons the switch
    REQ_VALID = 1'b1; REQ_SEL = 1'b1; QUIESCE_ACK = 1'b1;
    step();
    REQ_VALID = 1'b0;
    step();
    QUIESCE_ACK = 1'b0;
    step();
    step();
    chk("mid_settle_qreq", QUIESCE_REQ, 1);
    RST = 1'b1;
    step();
    chk("rs_qreq", QUIESCE_REQ, 0);
    chk("rs_sel", SELECT, 0);
    chk("rs_cur", CUR_SEL, 0);
    chk("rs_se", SELECT_ENABLE, 0);
    RST = 1'b0;
    step();
    chk("rerun_se", SELECT_ENABLE, 1);
    chk("rerun_sel", SELECT, 0);
    step();
    chk("rerun_ready", REQ_READY, 1);
    chk("rerun_cur", CUR_SEL, 0);
    repeat (12) step();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_mux_sequencer.md
CLOCK_MUX_SEQUENCER -- requirements
Module: clock_mux_sequencer

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 4: cycles held after a select update before the quiesce is released (1..255).
REQ-002 SHALL provide parameter QUIESCE_TIMEOUT, default 255: maximum cycles to wait for QUIESCE_ACK (1..255).
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- CLK  in  1  sole clock; the mux selector register is clocked by the same clock.
- RST  in  1  synchronous active-high reset.
- REQ_VALID  in  1  switch request.
- REQ_SEL  in  1  requested source: 1 = A_CLK, 0 = B_CLK.
- REQ_READY  out  1  request accepted when REQ_VALID && REQ_READY.
- QUIESCE_REQ  out  1  asks downstream logic on CLK_OUT to go idle.
- QUIESCE_ACK  in  1  downstream is idle; synchronized by the integrator.
- SELECT  out  1  to the mux SELECT.
- SELECT_ENABLE  out  1  to the mux SELECT_ENABLE.
- CUR_SEL  out  1  controller's copy of the mux selector.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- DONE  out  1  one-cycle pulse on successful completion.
- ERR  out  1  one-cycle pulse on quiesce timeout.

Function
REQ-004 SHALL implement the states INIT, IDLE, QUIESCE, SWITCH, SETTLE, RELEASE and FINISH.
REQ-005 INIT (the first cycle after reset) SHALL drive SELECT=0 and SELECT_ENABLE=1 for exactly one cycle, then go to IDLE; CUR_SEL=0.
REQ-006 REQ_READY SHALL be 1 only in IDLE; BUSY SHALL be the inverse of "state is IDLE".
REQ-007 On IDLE acceptance with REQ_SEL == CUR_SEL, the FSM SHALL go to FINISH without asserting QUIESCE_REQ or SELECT_ENABLE.
REQ-008 On IDLE acceptance with REQ_SEL != CUR_SEL, the FSM SHALL latch REQ_SEL into a target register, clear the wait counter and go to QUIESCE.
REQ-009 QUIESCE behaviour:
- QUIESCE_REQ=1.
- QUIESCE_ACK sampled 1 -> go to SWITCH.
- Otherwise the counter increments; counter reaching QUIESCE_TIMEOUT -> ERR=1 for one cycle, QUIESCE_REQ dropped, return to IDLE, CUR_SEL unchanged.
REQ-010 SWITCH SHALL last exactly one cycle, with SELECT=target, SELECT_ENABLE=1 and QUIESCE_REQ=1; CUR_SEL SHALL update to target at the end of that cycle. The mux output changes one cycle after SWITCH.
REQ-011 SETTLE SHALL hold QUIESCE_REQ=1 for exactly SETTLE_CYCLES cycles, then go to RELEASE.
REQ-012 RELEASE SHALL drive QUIESCE_REQ=0 and wait until QUIESCE_ACK is sampled 0, with no timeout, then go to FINISH.
REQ-013 FINISH SHALL assert DONE for one cycle, then return to IDLE.
REQ-014 Outside INIT and SWITCH, SELECT_ENABLE SHALL be 0. Outside SWITCH, SELECT SHALL equal CUR_SEL.
REQ-015 REQ_VALID and REQ_SEL SHALL be ignored outside IDLE. Requests are not queued.
REQ-016 DONE and ERR SHALL never assert in the same cycle.
REQ-017 The counter SHALL be 8 bits wide and SHALL saturate, never wrap.
REQ-018 Minimum switch latency, from the acceptance cycle to the DONE pulse with ACK immediate, SHALL be 1 (QUIESCE) + 1 (SWITCH) + SETTLE_CYCLES + 1 (RELEASE) + 1 (FINISH) cycles.

Reset
REQ-019 RST SHALL be sampled on the CLK rising edge and SHALL take priority over all transitions.
REQ-020 Under reset, outputs SHALL be:
- state = INIT;
- QUIESCE_REQ = 0;
- DONE = 0 and ERR = 0;
- REQ_READY = 0;
- SELECT_ENABLE = 0;
- SELECT = 0;
- CUR_SEL = 0;
- counter = 0.
REQ-021 Reset in any state, including mid-SETTLE, SHALL abandon the switch and re-run INIT, forcing the mux back to B_CLK.

Structure
REQ-022 The state encoding and the CLKSEL_A/CLKSEL_B constants SHALL live in a shared package clkmux_pkg.
REQ-023 The design SHALL be a single FSM module with no sub-modules. The SETTLE/timeout counter is shared within the module.
REQ-024 All outputs SHALL be registered or decoded directly from the state, with no input-to-output combinational paths except REQ_READY, which is a state decode only.

Verification
REQ-025 Release RST after 3 cycles -> exactly one SELECT_ENABLE pulse with SELECT=0, then REQ_READY=1 and CUR_SEL=0.
REQ-026 REQ_SEL=1 with ACK returned 2 cycles after QUIESCE_REQ, SETTLE_CYCLES=4 -> one SELECT_ENABLE with SELECT=1, QUIESCE_REQ high for 2+1+4 cycles, DONE once, CUR_SEL=1.
REQ-027 REQ_SEL equal to CUR_SEL -> DONE 1 cycle after acceptance; QUIESCE_REQ and SELECT_ENABLE stay 0.
REQ-028 QUIESCE_TIMEOUT=8 with ACK held 0 -> ERR on the 8th QUIESCE cycle, no SELECT_ENABLE, CUR_SEL unchanged, IDLE next cycle.
REQ-029 RST asserted during SETTLE -> INIT re-run with SELECT=0, QUIESCE_REQ=0 and CUR_SEL=0; no DONE pulse.
REQ-030 REQ_VALID toggling with alternating REQ_SEL while BUSY -> ignored; exactly one DONE per accepted request.
